// File: rtl/axis_pkt_arbiter.sv
// Round-robin packet arbiter for AXI-Stream sources: holds a grant for a whole packet,
// hands off with no bubble on tlast, and forcibly releases a source that stalls too long.
module axis_pkt_arbiter #(
  parameter int unsigned NREQ            = 2,
  parameter int unsigned TIMEOUT_CNT_MAX = 128,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            enable,
  input  logic                       m_tvalid,
  input  logic                       m_tready,
  input  logic                       m_tlast,
  output logic [NREQ-1:0]            grant,
  output logic [$clog2(NREQ+1)-1:0]  grant_idx,
  output logic                       grant_valid,
  output logic                       timeout_stb,
  output logic [CNT_WIDTH-1:0]       timeout_count
);

  localparam int unsigned GW = $clog2(NREQ + 1);
  localparam int unsigned SW = $clog2(TIMEOUT_CNT_MAX + 1);

  typedef enum logic {StIdle, StGranted} state_e;

  state_e               r_state, w_state_d;
  logic [NREQ-1:0]      r_grant, w_grant_d;
  logic [GW-1:0]        r_idx, w_idx_d;
  logic [GW-1:0]        r_ptr, w_ptr_d;
  logic                 r_gv;
  logic                 r_stb, w_stb_d;
  logic [CNT_WIDTH-1:0] r_count, w_count_d;
  logic [SW-1:0]        r_stall, w_stall_d;

  logic [NREQ-1:0]      w_eligible, w_mask, w_pick_oh;
  logic [GW-1:0]        w_pick_idx;
  logic                 w_beat, w_eop, w_timeout, w_rearb;
  int                   w_best, w_dist;

  assign w_beat     = m_tvalid & m_tready;
  assign w_eop      = w_beat & m_tlast;
  assign w_eligible = req & enable;
  // Counter would reach the limit on this edge; any beat (including tlast) takes precedence.
  assign w_timeout  = (r_state == StGranted) && !w_beat && (r_stall == SW'(TIMEOUT_CNT_MAX - 1));
  assign w_mask     = w_eligible & ~(w_timeout ? r_grant : '0);

  // Pick the set bit with the smallest rotational distance above the pointer.
  always_comb begin
    w_pick_idx = '0;
    w_best     = int'(NREQ);
    w_dist     = 0;
    for (int j = 0; j < int'(NREQ); j++) begin
      w_dist = (j + 2 * int'(NREQ) - int'(r_ptr) - 1) % int'(NREQ);
      if (w_mask[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick_idx = GW'(j);
      end
    end
  end

  assign w_pick_oh = NREQ'(1) << w_pick_idx;

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_idx_d   = r_idx;
    w_ptr_d   = r_ptr;
    w_stb_d   = 1'b0;
    w_count_d = r_count;
    w_stall_d = r_stall;
    w_rearb   = 1'b0;
    unique case (r_state)
      StIdle: w_rearb = 1'b1;
      StGranted: begin
        if (w_eop || w_timeout) begin
          w_rearb = 1'b1;
        end else begin
          w_stall_d = w_beat ? '0 : r_stall + SW'(1);
        end
        if (w_timeout) begin
          w_stb_d = 1'b1;
          if (r_count != '1) w_count_d = r_count + CNT_WIDTH'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_rearb) begin
      w_stall_d = '0;
      if (|w_mask) begin
        w_state_d = StGranted;
        w_grant_d = w_pick_oh;
        w_idx_d   = w_pick_idx;
        w_ptr_d   = w_pick_idx;
      end else begin
        w_state_d = StIdle;
        w_grant_d = '0;
        w_idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= GW'(NREQ - 1);
      r_gv    <= 1'b0;
      r_stb   <= 1'b0;
      r_count <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_idx   <= w_idx_d;
      r_ptr   <= w_ptr_d;
      r_gv    <= |w_grant_d;
      r_stb   <= w_stb_d;
      r_count <= w_count_d;
      r_stall <= w_stall_d;
    end
  end

  assign grant         = r_grant;
  assign grant_idx     = r_idx;
  assign grant_valid   = r_gv;
  assign timeout_stb   = r_stb;
  assign timeout_count = r_count;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: a 2-source instance (short timeout, 2-bit counter)
// checked through a grant scoreboard, plus a 4-source instance for index and wrap checks.
module tb_axis_pkt_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  a_req, a_en, a_grant, a_idx, a_cnt;
  logic        a_tv, a_tr, a_tl, a_gv, a_stb;
  logic [3:0]  b_req, b_en, b_grant;
  logic [2:0]  b_idx;
  logic [15:0] b_cnt;
  logic        b_tv, b_tr, b_tl, b_gv, b_stb;

  axis_pkt_arbiter #(.NREQ(2), .TIMEOUT_CNT_MAX(4), .CNT_WIDTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .enable(a_en),
    .m_tvalid(a_tv), .m_tready(a_tr), .m_tlast(a_tl),
    .grant(a_grant), .grant_idx(a_idx), .grant_valid(a_gv),
    .timeout_stb(a_stb), .timeout_count(a_cnt)
  );

  axis_pkt_arbiter #(.NREQ(4), .TIMEOUT_CNT_MAX(4), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .enable(b_en),
    .m_tvalid(b_tv), .m_tready(b_tr), .m_tlast(b_tl),
    .grant(b_grant), .grant_idx(b_idx), .grant_valid(b_gv),
    .timeout_stb(b_stb), .timeout_count(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_prev = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every new non-zero grant on u_a must match the next queued expectation.
  always @(negedge clk) begin
    if (a_grant != mon_prev && a_grant != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_grant: observed %b expected none", a_grant);
      end else begin
        check("sb_grant", 32'(a_grant), 32'(exp_q.pop_front()));
      end
    end
    mon_prev = a_grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_req = '0; a_en = '0; a_tv = 0; a_tr = 0; a_tl = 0;
    b_req = '0; b_en = '0; b_tv = 0; b_tr = 0; b_tl = 0;
    tick(); tick();
    check("rst_grant", 32'(a_grant), 0);
    check("rst_gv", 32'(a_gv), 0);
    check("rst_idx", 32'(a_idx), 0);
    check("rst_stb", 32'(a_stb), 0);
    check("rst_cnt", 32'(a_cnt), 0);
    check("rst_b_grant", 32'(b_grant), 0);
    rst_n = 1'b1;
    tick();
    check("idle_stay", 32'(a_grant), 0);

    // Four sources: index reporting and pointer wrap.
    b_req = 4'b1010; b_en = 4'hF; b_tv = 1; b_tr = 1; b_tl = 0;
    tick();
    check("b_first", 32'(b_grant), 32'h2);
    check("b_first_idx", 32'(b_idx), 1);
    check("b_first_gv", 32'(b_gv), 1);
    b_tl = 1;
    tick();
    check("b_second", 32'(b_grant), 32'h8);
    check("b_second_idx", 32'(b_idx), 3);
    b_req = 4'b0000;
    tick();
    check("b_idle", 32'(b_grant), 0);
    check("b_idle_gv", 32'(b_gv), 0);
    check("b_idle_idx", 32'(b_idx), 0);
    b_req = 4'b0011;
    tick();
    check("b_wrap", 32'(b_grant), 32'h1);
    tick();
    check("b_wrap_next", 32'(b_grant), 32'h2);
    b_req = 4'b0000;
    tick();
    b_tv = 0; b_tl = 0;

    // Back-to-back 3-beat packets, zero-bubble alternation.
    a_req = 2'b11; a_en = 2'b11; a_tr = 1; a_tv = 1; a_tl = 0;
    exp_q.push_back(2'b01);
    tick();
    for (int k = 0; k < 4; k++) begin
      a_tl = 0;
      tick(); tick();
      a_tl = 1;
      if (k == 3) a_req = 2'b00;
      else exp_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("eop_handoff_gv", 32'(a_gv), (k != 3) ? 1 : 0);
    end
    a_tl = 0; a_tv = 0;

    // tlast on the cycle the stall counter would expire: eop wins.
    a_req = 2'b11;
    exp_q.push_back(2'b01);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_stb", 32'(a_stb), 0);
    end
    a_tv = 1; a_tl = 1;
    exp_q.push_back(2'b10);
    tick();
    check("eop_wins_stb", 32'(a_stb), 0);
    check("eop_wins_cnt", 32'(a_cnt), 0);
    exp_q.push_back(2'b01);
    tick();
    a_tv = 0; a_tl = 0;

    // Repeated stalls: forced release, alternating grant, counter saturates at 3.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("to_no_stb", 32'(a_stb), 0);
      end
      exp_q.push_back((t % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      check("to_stb", 32'(a_stb), 1);
      check("to_cnt", 32'(a_cnt), (t < 3) ? t + 1 : 3);
    end

    // Disabling the granted source mid-packet does not cut the packet.
    a_tv = 1; a_tl = 1;
    exp_q.push_back(2'b01);
    tick();
    check("stb_single", 32'(a_stb), 0);
    a_tl = 0; a_en = 2'b10;
    tick();
    check("en_hold", 32'(a_grant), 32'h1);
    tick();
    check("en_hold", 32'(a_grant), 32'h1);
    a_tl = 1;
    exp_q.push_back(2'b10);
    tick();
    tick();
    check("skip_src0", 32'(a_grant), 32'h2);
    check("skip_src0_idx", 32'(a_idx), 1);

    // Reset mid-packet.
    a_tl = 0; a_en = 2'b11;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_grant", 32'(a_grant), 0);
    check("mid_rst_cnt", 32'(a_cnt), 0);
    check("mid_rst_stb", 32'(a_stb), 0);
    check("mid_rst_gv", 32'(a_gv), 0);
    rst_n = 1'b1;
    exp_q.push_back(2'b01);
    tick();
    check("post_rst_idx", 32'(a_idx), 0);
    check("post_rst_gv", 32'(a_gv), 1);
    a_req = 2'b00; a_tl = 1;
    tick();
    check("final_idle", 32'(a_grant), 0);
    tick();
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal range 1..8).
REQ-002 SHALL have parameter TIMEOUT_CNT_MAX, default 128, stall cycles before forced release (legal range 2..65535).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of timeout_count.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req, input, NREQ, per-source "packet available" (FIFO not empty).
REQ-008 SHALL have port enable, input, NREQ, per-source arbitration mask; 1 means eligible.
REQ-009 SHALL have port m_tvalid, input, 1, muxed output valid, monitored only.
REQ-010 SHALL have port m_tready, input, 1, downstream ready, monitored only.
REQ-011 SHALL have port m_tlast, input, 1, muxed output last, monitored only.
REQ-012 SHALL have port grant, output, NREQ, one-hot grant, or all-zero when idle.
REQ-013 SHALL have port grant_idx, output, $clog2(NREQ+1), binary index of grant, 0 when idle.
REQ-014 SHALL have port grant_valid, output, 1, high when grant is non-zero.
REQ-015 SHALL have port timeout_stb, output, 1, one-cycle pulse on forced release.
REQ-016 SHALL have port timeout_count, output, CNT_WIDTH, saturating count of forced releases.

Function
REQ-017 SHALL implement a two-state FSM: IDLE (grant=0) and GRANTED (grant one-hot, registered).
REQ-018 SHALL define eligible = req & enable, and SHALL register all outputs (no combinational input-to-output path).
REQ-019 IDLE: if eligible != 0, the FSM SHALL enter GRANTED on the next edge with grant = first eligible bit searching upward from (ptr+1) mod NREQ. Latency is 1 cycle.
REQ-020 IDLE with eligible == 0: the FSM SHALL stay in IDLE.
REQ-021 On every grant, ptr SHALL load the granted index. After reset, ptr = NREQ-1, so source 0 has first priority.
REQ-022 GRANTED: grant SHALL hold regardless of changes to req or enable until a release event occurs.
REQ-023 Release event (end of packet): m_tvalid & m_tready & m_tlast in GRANTED.
REQ-024 On end of packet, the next-cycle grant SHALL be the round-robin pick computed from the current eligible (zero bubble). If none is eligible, the FSM SHALL go to IDLE.
REQ-025 A beat is m_tvalid & m_tready. The stall counter SHALL clear on every beat and on every new grant, and SHALL increment on each GRANTED cycle without a beat.
REQ-026 When the stall counter reaches TIMEOUT_CNT_MAX, the block SHALL:
  - release the grant, re-arbitrating as in REQ-024 but excluding the timed-out source for that one decision;
  - pulse timeout_stb high for exactly 1 cycle;
  - increment timeout_count.
REQ-027 If end of packet and the timeout condition coincide, end of packet SHALL win: no timeout_stb and no count increment.
REQ-028 timeout_count SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-029 With NREQ=1, the round-robin pick SHALL always be source 0.
REQ-030 Deasserting enable for the granted source mid-packet SHALL NOT truncate the packet; the source becomes ineligible only at the next arbitration.
REQ-031 grant_idx and grant_valid SHALL always be consistent with grant in the same cycle.

Reset
REQ-032 While rst_n=0 at a rising edge, the block SHALL set: state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout_stb=0, timeout_count=0, stall counter=0, ptr=NREQ-1.
REQ-033 Reset asserted mid-packet SHALL drop the grant on the next edge with no timeout_stb.
REQ-034 After rst_n returns to 1, arbitration SHALL resume per REQ-019.

Verification
REQ-035 NREQ=2, req=2'b11 held, enable=2'b11, 3-beat packets, m_tready=1 -> grant sequence 01,10,01,10; each switch occurs on the edge after the tlast beat with no idle cycle.
REQ-036 NREQ=4, req=4'b1010 from IDLE -> grant=0010 one cycle later, grant_idx=1. After its tlast, grant=1000, grant_idx=3.
REQ-037 TIMEOUT_CNT_MAX=4, source 0 granted, m_tvalid=0 for 4 cycles, req=2'b11 -> timeout_stb pulses once, grant moves to 10, timeout_count=1.
REQ-038 TIMEOUT_CNT_MAX=4, tlast beat on the same cycle the counter would hit 4 -> no timeout_stb, timeout_count unchanged, normal round-robin handoff.
REQ-039 enable[0] deasserted mid-packet of source 0 -> grant held through tlast; source 0 is then skipped while req=2'b11.
REQ-040 rst_n=0 for 1 cycle while granted -> grant=0 and timeout_count=0 next cycle. With req=2'b11 after release, first grant = 01.
